// File: rtl/fc_lcc_tb_services.sv
// FC/LCC testbench-service decoder: turns mailbox opcodes 0x90-0x9F into registered
// force/release levels and timed reset/escalation pulses for the TB glue.
module fc_lcc_tb_services #(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int ESC_PULSE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       cptra_rst_b,
    input  logic       tb_service_cmd_valid,
    input  logic [7:0] tb_service_cmd,
    output logic       fc_lcc_rst_req,
    output logic       awuser_ovr_en,
    output logic       awuser_ovr_sel,
    output logic       zeroize_force,
    output logic       lc_tokens_force,
    output logic       rma_ppd_force,
    output logic       esc_trigger,
    output logic       cmd_ack,
    output logic [7:0] last_cmd
);
    localparam logic [7:0] CMD_FC_LCC_RESET   = 8'h90;
    localparam logic [7:0] CMD_AWUSER_CORE    = 8'h91;
    localparam logic [7:0] CMD_AWUSER_MCU     = 8'h92;
    localparam logic [7:0] CMD_AWUSER_RELEASE = 8'h93;
    localparam logic [7:0] CMD_ZEROIZE_SET    = 8'h94;
    localparam logic [7:0] CMD_ZEROIZE_CLR    = 8'h95;
    localparam logic [7:0] CMD_LC_TOKENS_SET  = 8'h96;
    localparam logic [7:0] CMD_LC_TOKENS_CLR  = 8'h97;
    localparam logic [7:0] CMD_RMA_PPD_SET    = 8'h98;
    localparam logic [7:0] CMD_RMA_PPD_CLR    = 8'h99;
    localparam logic [7:0] CMD_FC_ESCALATE    = 8'h9A;
    localparam logic [7:0] CMD_RELEASE_ALL    = 8'h9F;

    localparam int N_PULSE = 2;
    localparam int P_RST   = 0;
    localparam int P_ESC   = 1;

    logic               valid_q, valid_d;
    logic               armed_q, armed_d;
    logic               awuser_ovr_en_q, awuser_ovr_en_d;
    logic               awuser_ovr_sel_q, awuser_ovr_sel_d;
    logic               zeroize_force_q, zeroize_force_d;
    logic               lc_tokens_force_q, lc_tokens_force_d;
    logic               rma_ppd_force_q, rma_ppd_force_d;
    logic               cmd_ack_q, cmd_ack_d;
    logic [7:0]         last_cmd_q, last_cmd_d;
    logic               accept;
    logic               recognised;
    logic [N_PULSE-1:0] pulse_load;
    logic [N_PULSE-1:0] pulse_clear;
    logic [N_PULSE-1:0] pulse_active;

    // armed_q blocks the first edge after reset so a valid already high at release
    // is only sampled into valid_q and never executes.
    always_comb begin
        valid_d           = tb_service_cmd_valid;
        armed_d           = 1'b1;
        accept            = tb_service_cmd_valid & ~valid_q & armed_q;
        recognised        = 1'b0;
        awuser_ovr_en_d   = awuser_ovr_en_q;
        awuser_ovr_sel_d  = awuser_ovr_sel_q;
        zeroize_force_d   = zeroize_force_q;
        lc_tokens_force_d = lc_tokens_force_q;
        rma_ppd_force_d   = rma_ppd_force_q;
        cmd_ack_d         = 1'b0;
        last_cmd_d        = last_cmd_q;
        pulse_load        = '0;
        pulse_clear       = '0;
        if (accept) begin
            recognised = 1'b1;
            case (tb_service_cmd)
                CMD_FC_LCC_RESET:   pulse_load[P_RST] = 1'b1;
                CMD_AWUSER_CORE: begin
                    awuser_ovr_en_d  = 1'b1;
                    awuser_ovr_sel_d = 1'b0;
                end
                CMD_AWUSER_MCU: begin
                    awuser_ovr_en_d  = 1'b1;
                    awuser_ovr_sel_d = 1'b1;
                end
                CMD_AWUSER_RELEASE: awuser_ovr_en_d   = 1'b0;
                CMD_ZEROIZE_SET:    zeroize_force_d   = 1'b1;
                CMD_ZEROIZE_CLR:    zeroize_force_d   = 1'b0;
                CMD_LC_TOKENS_SET:  lc_tokens_force_d = 1'b1;
                CMD_LC_TOKENS_CLR:  lc_tokens_force_d = 1'b0;
                CMD_RMA_PPD_SET:    rma_ppd_force_d   = 1'b1;
                CMD_RMA_PPD_CLR:    rma_ppd_force_d   = 1'b0;
                CMD_FC_ESCALATE:    pulse_load[P_ESC] = 1'b1;
                CMD_RELEASE_ALL: begin
                    awuser_ovr_en_d   = 1'b0;
                    awuser_ovr_sel_d  = 1'b0;
                    zeroize_force_d   = 1'b0;
                    lc_tokens_force_d = 1'b0;
                    rma_ppd_force_d   = 1'b0;
                    pulse_clear       = '1;
                end
                default:            recognised = 1'b0;
            endcase
        end
        if (recognised) begin
            cmd_ack_d  = 1'b1;
            last_cmd_d = tb_service_cmd;
        end
    end

    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            valid_q           <= 1'b0;
            armed_q           <= 1'b0;
            awuser_ovr_en_q   <= 1'b0;
            awuser_ovr_sel_q  <= 1'b0;
            zeroize_force_q   <= 1'b0;
            lc_tokens_force_q <= 1'b0;
            rma_ppd_force_q   <= 1'b0;
            cmd_ack_q         <= 1'b0;
            last_cmd_q        <= 8'h00;
        end else begin
            valid_q           <= valid_d;
            armed_q           <= armed_d;
            awuser_ovr_en_q   <= awuser_ovr_en_d;
            awuser_ovr_sel_q  <= awuser_ovr_sel_d;
            zeroize_force_q   <= zeroize_force_d;
            lc_tokens_force_q <= lc_tokens_force_d;
            rma_ppd_force_q   <= rma_ppd_force_d;
            cmd_ack_q         <= cmd_ack_d;
            last_cmd_q        <= last_cmd_d;
        end
    end

    // Timed outputs: a load sets the counter to N, giving exactly N high cycles;
    // a reload mid-pulse restarts the count.
    for (genvar gi = 0; gi < N_PULSE; gi++) begin : g_pulse
        localparam logic [7:0] LEN = (gi == P_RST) ? 8'(RST_PULSE_CYCLES) : 8'(ESC_PULSE_CYCLES);
        logic [7:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (pulse_clear[gi]) begin
                cnt_d = 8'd0;
            end else if (pulse_load[gi]) begin
                cnt_d = LEN;
            end else if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
            end
        end

        always_ff @(posedge clk or negedge cptra_rst_b) begin
            if (!cptra_rst_b) begin
                cnt_q <= 8'd0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign pulse_active[gi] = (cnt_q != 8'd0);
    end

    assign fc_lcc_rst_req  = pulse_active[P_RST];
    assign esc_trigger     = pulse_active[P_ESC];
    assign awuser_ovr_en   = awuser_ovr_en_q;
    assign awuser_ovr_sel  = awuser_ovr_sel_q;
    assign zeroize_force   = zeroize_force_q;
    assign lc_tokens_force = lc_tokens_force_q;
    assign rma_ppd_force   = rma_ppd_force_q;
    assign cmd_ack         = cmd_ack_q;
    assign last_cmd        = last_cmd_q;
endmodule

// File: tb/tb_fc_lcc_tb_services.sv
// Self-checking bench for fc_lcc_tb_services: a time-stamp model of the opcode rules
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_fc_lcc_tb_services;
    localparam int RST_N = 16;
    localparam int ESC_N = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] cmd   = 8'h00;
    logic       fc_lcc_rst_req, awuser_ovr_en, awuser_ovr_sel, zeroize_force;
    logic       lc_tokens_force, rma_ppd_force, esc_trigger, cmd_ack;
    logic [7:0] last_cmd;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fc_lcc_tb_services #(
        .RST_PULSE_CYCLES(RST_N),
        .ESC_PULSE_CYCLES(ESC_N)
    ) dut (
        .clk                  (clk),
        .cptra_rst_b          (rst_n),
        .tb_service_cmd_valid (valid),
        .tb_service_cmd       (cmd),
        .fc_lcc_rst_req       (fc_lcc_rst_req),
        .awuser_ovr_en        (awuser_ovr_en),
        .awuser_ovr_sel       (awuser_ovr_sel),
        .zeroize_force        (zeroize_force),
        .lc_tokens_force      (lc_tokens_force),
        .rma_ppd_force        (rma_ppd_force),
        .esc_trigger          (esc_trigger),
        .cmd_ack              (cmd_ack),
        .last_cmd             (last_cmd)
    );

    // Model: pulses are tracked as the edge count at which they expire.
    int         cyc     = 0;
    int         rst_end = 0;
    int         esc_end = 0;
    logic       m_prev_valid = 1'b0, m_armed = 1'b0;
    logic       m_en = 1'b0, m_sel = 1'b0, m_zero = 1'b0, m_lc = 1'b0, m_rma = 1'b0, m_ack = 1'b0;
    logic [7:0] m_last = 8'h00;
    bit         chk_en = 1'b0;
    int         rst_hi = 0, esc_hi = 0, ack_n = 0;
    logic [15:0] act_vec, exp_vec;

    function automatic bit known_op(input logic [7:0] c);
        return (c >= 8'h90 && c <= 8'h9A) || c == 8'h9F;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_end <= 0; esc_end <= 0;
            m_prev_valid <= 1'b0; m_armed <= 1'b0;
            m_en <= 1'b0; m_sel <= 1'b0; m_zero <= 1'b0; m_lc <= 1'b0; m_rma <= 1'b0;
            m_ack <= 1'b0; m_last <= 8'h00;
        end else begin
            cyc          <= cyc + 1;
            m_ack        <= 1'b0;
            m_prev_valid <= valid;
            m_armed      <= 1'b1;
            if (valid && !m_prev_valid && m_armed && known_op(cmd)) begin
                m_ack  <= 1'b1;
                m_last <= cmd;
                case (cmd)
                    8'h90: rst_end <= cyc + 1 + RST_N;
                    8'h91: begin m_en <= 1'b1; m_sel <= 1'b0; end
                    8'h92: begin m_en <= 1'b1; m_sel <= 1'b1; end
                    8'h93: m_en   <= 1'b0;
                    8'h94: m_zero <= 1'b1;
                    8'h95: m_zero <= 1'b0;
                    8'h96: m_lc   <= 1'b1;
                    8'h97: m_lc   <= 1'b0;
                    8'h98: m_rma  <= 1'b1;
                    8'h99: m_rma  <= 1'b0;
                    8'h9A: esc_end <= cyc + 1 + ESC_N;
                    8'h9F: begin
                        m_en <= 1'b0; m_sel <= 1'b0; m_zero <= 1'b0; m_lc <= 1'b0; m_rma <= 1'b0;
                        rst_end <= 0; esc_end <= 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            act_vec = {fc_lcc_rst_req, awuser_ovr_en, awuser_ovr_sel, zeroize_force,
                       lc_tokens_force, rma_ppd_force, esc_trigger, cmd_ack, last_cmd};
            exp_vec = {(cyc < rst_end), m_en, m_sel, m_zero, m_lc, m_rma,
                       (cyc < esc_end), m_ack, m_last};
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL model_cycle t=%0t got=%04h expected=%04h", $time, act_vec, exp_vec);
            end
            if (rst_n) begin
                if (fc_lcc_rst_req) rst_hi++;
                if (esc_trigger)    esc_hi++;
                if (cmd_ack)        ack_n++;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] c, input int hold);
        @(posedge clk); #1;
        valid = 1'b1;
        cmd   = c;
        repeat (hold) @(posedge clk);
        #1;
        valid = 1'b0;
        $display("cmd %02h held %0d: ack=%0b last=%02h", c, hold, cmd_ack, last_cmd);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        rst_hi = 0; esc_hi = 0; ack_n = 0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rst_req", fc_lcc_rst_req, 0);
        chk("reset_esc", esc_trigger, 0);
        chk("reset_ack", cmd_ack, 0);
        chk("reset_last", last_cmd, 0);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Held valid with reset opcode: one execution, 16-cycle pulse.
        clear_counts();
        send(8'h90, 40);
        idle(20);
        chk("rst_pulse_len", rst_hi, 16);
        chk("rst_ack_count", ack_n, 1);
        chk("rst_last_cmd", last_cmd, 8'h90);

        send(8'h92, 1);
        chk("mcu_en", awuser_ovr_en, 1);
        chk("mcu_sel", awuser_ovr_sel, 1);
        chk("mcu_ack", cmd_ack, 1);
        send(8'h93, 1);
        chk("release_en", awuser_ovr_en, 0);
        chk("release_sel", awuser_ovr_sel, 1);
        send(8'h91, 1);
        chk("core_en", awuser_ovr_en, 1);
        chk("core_sel", awuser_ovr_sel, 0);
        idle(2);

        // Escalation retriggered two cycles after the first load.
        clear_counts();
        send(8'h9A, 1);
        send(8'h9A, 1);
        idle(10);
        chk("esc_retrigger_len", esc_hi, 6);
        chk("esc_ack_count", ack_n, 2);

        send(8'h94, 1);
        send(8'h96, 1);
        send(8'h98, 1);
        send(8'h94, 1);
        chk("zeroize_set", zeroize_force, 1);
        chk("lc_set", lc_tokens_force, 1);
        chk("rma_set", rma_ppd_force, 1);
        send(8'h90, 1);
        send(8'h9A, 1);
        send(8'h9F, 1);
        chk("all_zeroize", zeroize_force, 0);
        chk("all_lc", lc_tokens_force, 0);
        chk("all_rma", rma_ppd_force, 0);
        chk("all_awuser", awuser_ovr_en, 0);
        chk("all_rst_req", fc_lcc_rst_req, 0);
        chk("all_esc", esc_trigger, 0);
        chk("all_last", last_cmd, 8'h9F);
        idle(3);

        send(8'h94, 1);
        idle(2);
        clear_counts();
        send(8'h20, 1);
        send(8'h9C, 1);
        send(8'h9B, 1);
        idle(3);
        chk("ignored_ack", ack_n, 0);
        chk("ignored_last", last_cmd, 8'h94);
        chk("ignored_zeroize", zeroize_force, 1);

        // Asynchronous reset in the middle of a reset pulse.
        send(8'h90, 1);
        send(8'h96, 1);
        idle(2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", fc_lcc_rst_req, 0);
        chk("async_lc", lc_tokens_force, 0);
        chk("async_zeroize", zeroize_force, 0);
        chk("async_last", last_cmd, 0);
        valid = 1'b1;
        cmd   = 8'h96;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        clear_counts();
        idle(6);
        chk("bringup_lc", lc_tokens_force, 0);
        chk("bringup_ack", ack_n, 0);
        valid = 1'b0;
        idle(1);
        send(8'h96, 1);
        chk("post_bringup_lc", lc_tokens_force, 1);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
